// File: rtl/alu_pkg.sv
// Shared ALU op encoding plus the scheduler's in-flight tag type.
// Tag id is sized for the largest supported requester count.
package alu_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_MULT = 3'd5
  } alu_op_t;

  localparam int MAX_NREQ = 8;
  localparam int TAG_ID_W = $clog2(MAX_NREQ);

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } sched_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority grant: first set request at or after ptr, wrapping; zero latency.
// Backpressure: no grant while rst is high or when no request is pending.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int PW  = $clog2(NREQ)
) (
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx
);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      // ptr is always < NREQ, so one conditional subtract is a full modulo
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
    if (rst) grant = '0;
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin sharing of one pipelined ALU among NREQ requesters; response LAT+2 edges after transfer.
// Backpressure: at most one request accepted per cycle; ready never depends on response state.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int DWIDTH = 11,
  parameter int NREQ   = 4,
  parameter int LAT    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid_i,
  output logic [NREQ-1:0]            req_ready_o,
  input  logic [NREQ*ALU_OP_W-1:0]   req_op_i,
  input  logic [NREQ*DWIDTH-1:0]     req_a_i,
  input  logic [NREQ*DWIDTH-1:0]     req_b_i,
  output logic                       alu_valid_o,
  output logic [ALU_OP_W-1:0]        alu_op_o,
  output logic [DWIDTH-1:0]          alu_a_o,
  output logic [DWIDTH-1:0]          alu_b_o,
  input  logic [2*DWIDTH-1:0]        alu_res_i,
  output logic [NREQ-1:0]            rsp_valid_o,
  output logic [2*DWIDTH-1:0]        rsp_res_o,
  output logic                       busy_o
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   issue_id_q;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            xfer;
  sched_tag_t      tag_q [LAT];
  sched_tag_t      last_tag;
  logic [LAT-1:0]  tag_vld;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .rst       (rst),
    .req       (req_valid_i),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready_o = grant;
  assign xfer        = |(req_valid_i & grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      issue_id_q  <= '0;
      alu_valid_o <= 1'b0;
      alu_op_o    <= '0;
      alu_a_o     <= '0;
      alu_b_o     <= '0;
    end else begin
      alu_valid_o <= xfer;
      if (xfer) begin
        ptr_q      <= (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + PW'(1);
        issue_id_q <= grant_idx;
        alu_op_o   <= req_op_i[grant_idx*ALU_OP_W +: ALU_OP_W];
        alu_a_o    <= req_a_i[grant_idx*DWIDTH +: DWIDTH];
        alu_b_o    <= req_b_i[grant_idx*DWIDTH +: DWIDTH];
      end
    end
  end

  // Stage 0 follows the issue register, so the tag lines up with alu_res_i
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= '{valid: alu_valid_o, id: TAG_ID_W'(issue_id_q)};
      for (int s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign last_tag = tag_q[LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_o <= '0;
      rsp_res_o   <= '0;
    end else begin
      rsp_valid_o <= last_tag.valid ? (NREQ'(1) << last_tag.id) : '0;
      if (last_tag.valid) rsp_res_o <= alu_res_i;
    end
  end

  always_comb begin
    tag_vld = '0;
    for (int s = 0; s < LAT; s++) tag_vld[s] = tag_q[s].valid;
  end

  assign busy_o = alu_valid_o | (|tag_vld);

endmodule
